// File: rtl/button_pulse_gen_pkg.sv
// Shared types and constants for the two-button front end.
package button_pkg;

    // Default number of stable synchronised samples needed to accept a level change
    localparam int DEBOUNCE_DEFAULT = 4;

    // Debounce state of one button channel
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } chan_state_t;

endpackage

// File: rtl/button_pulse_gen_if.sv
// Bundles the raw button inputs and the conditioned press pulses.
interface button_pulse_gen_if;

    logic btn_a_raw;
    logic btn_b_raw;
    logic a;
    logic b;

    // The side that owns the buttons and consumes the pulses
    modport master (
        output btn_a_raw,
        output btn_b_raw,
        input  a,
        input  b
    );

    // The conditioning block itself
    modport slave (
        input  btn_a_raw,
        input  btn_b_raw,
        output a,
        output b
    );

endinterface

// File: rtl/button_pulse_gen_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and counter.
// press_evt is high for the single cycle in which a press is accepted.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    chan_state_t      state;
    chan_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Bring the asynchronous button into the clock domain; only the second flop is used
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // State and stability counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A level change is accepted only after the counter sees it stable through CNT_LAST
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // The press event marks the PRESS_CHK to HELD transition; releases are silent
    always_comb begin
        press_evt = (state == PRESS_CHK) && sync && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/button_pulse_gen.sv
// Two-button conditioning front end: two debounce channels feeding registered,
// mutually exclusive one-cycle press pulses. A simultaneous press emits a, then b.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic         clk,
    input logic         reset,
    button_pulse_gen_if.slave bus
);

    logic evt_a;
    logic evt_b;
    logic a_q;
    logic b_q;
    logic b_pend;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.btn_a_raw),
        .press_evt (evt_a)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.btn_b_raw),
        .press_evt (evt_b)
    );

    // Register the pulses; a colliding b event is deferred by one cycle so a and b never overlap
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            b_pend <= 1'b0;
        end else begin
            a_q    <= evt_a;
            b_q    <= (evt_b & ~evt_a) | b_pend;
            b_pend <= evt_b & evt_a;
        end
    end

    assign bus.a = a_q;
    assign bus.b = b_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios with expected
// pulse cycles derived from the debounce latency, plus a randomized bouncing
// run checked against a run-length reference model.
module tb_button_pulse_gen;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    button_pulse_gen_if bus ();

    button_pulse_gen #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Reference model: each channel keeps a debounced level and a count of
    // consecutive synchronised samples disagreeing with it; D+1 in a row flips
    // the level, and a flip to pressed is a press event in that cycle.
    logic m_s1  [2] = '{1'b0, 1'b0};
    logic m_s2  [2] = '{1'b0, 1'b0};
    logic m_lvl [2] = '{1'b0, 1'b0};
    logic m_evt [2] = '{1'b0, 1'b0};
    int   m_run [2] = '{0, 0};
    logic m_raw [2];
    logic m_pend = 1'b0;
    logic exp_a  = 1'b0;
    logic exp_b  = 1'b0;

    // Advance the reference model on every rising edge using pre-edge inputs
    always @(posedge clk) begin
        m_raw[0] = bus.btn_a_raw;
        m_raw[1] = bus.btn_b_raw;
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_s1[ch]  = 1'b0;
                m_s2[ch]  = 1'b0;
                m_lvl[ch] = 1'b0;
                m_evt[ch] = 1'b0;
                m_run[ch] = 0;
            end
            m_pend = 1'b0;
            exp_a  = 1'b0;
            exp_b  = 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                m_evt[ch] = 1'b0;
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] == D + 1) begin
                        m_lvl[ch] = m_s2[ch];
                        m_run[ch] = 0;
                        m_evt[ch] = m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            exp_a  = m_evt[0];
            exp_b  = (m_evt[1] && !m_evt[0]) || m_pend;
            m_pend = m_evt[0] && m_evt[1];
            for (int ch = 0; ch < 2; ch++) begin
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = m_raw[ch];
            end
        end
    end

    // Drive inputs at the falling edge, then return at the next falling edge
    task automatic tick(input logic ra, input logic rb, input logic rst);
        bus.btn_a_raw = ra;
        bus.btn_b_raw = rb;
        reset         = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs are low during and right after reset
    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, k < 2);
            checks++;
            if (bus.a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_a k=%0d got=%b want=0", k, bus.a);
            end
            checks++;
            if (bus.b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_b k=%0d got=%b want=0", k, bus.b);
            end
        end
    endtask

    // Clean hold of A: one pulse after edge D+2, nothing more while held or on release
    task automatic test_clean_press();
        for (int k = 0; k < 34; k++) begin
            tick(k < 20, 1'b0, 1'b0);
            checks++;
            if (bus.a !== (k == D + 2)) begin
                errors++;
                $display("[TB] FAIL clean_a k=%0d got=%b want=%b", k, bus.a, k == D + 2);
            end
            checks++;
            if (bus.b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clean_b k=%0d got=%b want=0", k, bus.b);
            end
        end
    endtask

    // Bouncy press then bouncy release of A: exactly one pulse, timed from the final rise
    task automatic test_bounce();
        logic [4:0] press_pat   = 5'b10101;
        logic [7:0] release_pat = 8'b11001100;
        for (int k = 0; k < 20; k++) begin
            tick((k < 5) ? press_pat[k] : 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.a !== (k == 4 + D + 2)) begin
                errors++;
                $display("[TB] FAIL bounce_press_a k=%0d got=%b want=%b", k, bus.a, k == 4 + D + 2);
            end
        end
        for (int k = 0; k < 22; k++) begin
            tick((k < 8) ? release_pat[k] : 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bounce_release_a k=%0d got=%b want=0", k, bus.a);
            end
        end
    endtask

    // A 3-cycle blip on B is rejected, and a later clean B press still works
    task automatic test_short_glitch();
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, k < 3, 1'b0);
            checks++;
            if (bus.b !== 1'b0 || bus.a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch_b k=%0d got a=%b b=%b want a=0 b=0", k, bus.a, bus.b);
            end
        end
        for (int k = 0; k < 26; k++) begin
            tick(1'b0, k < 12, 1'b0);
            checks++;
            if (bus.b !== (k == D + 2)) begin
                errors++;
                $display("[TB] FAIL glitch_then_press_b k=%0d got=%b want=%b", k, bus.b, k == D + 2);
            end
        end
    endtask

    // Both buttons rise together: a at N, b at N+1, never together
    task automatic test_simultaneous();
        for (int k = 0; k < 26; k++) begin
            tick(k < 12, k < 12, 1'b0);
            checks++;
            if (bus.a !== (k == D + 2)) begin
                errors++;
                $display("[TB] FAIL simul_a k=%0d got=%b want=%b", k, bus.a, k == D + 2);
            end
            checks++;
            if (bus.b !== (k == D + 3)) begin
                errors++;
                $display("[TB] FAIL simul_b k=%0d got=%b want=%b", k, bus.b, k == D + 3);
            end
            checks++;
            if ((bus.a & bus.b) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_excl k=%0d got a&b=%b want=0", k, bus.a & bus.b);
            end
        end
    endtask

    // Reset during debounce of A restarts it; latency counts from edge 5, the first edge out of reset
    task automatic test_reset_mid();
        for (int k = 0; k < 34; k++) begin
            tick(k < 20, 1'b0, k == 4);
            checks++;
            if (bus.a !== (k == 5 + D + 2)) begin
                errors++;
                $display("[TB] FAIL reset_mid_a k=%0d got=%b want=%b", k, bus.a, k == 5 + D + 2);
            end
        end
    endtask

    // Reset on the cycle the deferred b would appear discards it; held buttons re-debounce
    task automatic test_reset_pending();
        for (int k = 0; k < 34; k++) begin
            tick(k < 20, k < 20, k == D + 3);
            checks++;
            if (bus.a !== (k == D + 2 || k == D + 4 + D + 2)) begin
                errors++;
                $display("[TB] FAIL reset_pend_a k=%0d got=%b", k, bus.a);
            end
            checks++;
            if (bus.b !== (k == D + 4 + D + 3)) begin
                errors++;
                $display("[TB] FAIL reset_pend_b k=%0d got=%b want=%b", k, bus.b, k == D + 4 + D + 3);
            end
        end
    endtask

    // Press, release, press again: two pulses, each D+2 after its press
    task automatic test_repeat();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 14; k++) begin
                tick(p != 1, 1'b0, 1'b0);
                checks++;
                if (bus.a !== (p != 1 && k == D + 2)) begin
                    errors++;
                    $display("[TB] FAIL repeat_a phase=%0d k=%0d got=%b want=%b", p, k, bus.a, p != 1 && k == D + 2);
                end
            end
        end
        for (int k = 0; k < 14; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Random run-length bouncing on both buttons with rare resets, checked against the model
    task automatic test_random();
        logic lvl [2] = '{1'b0, 1'b0};
        int   rem [2] = '{0, 0};
        logic rst;
        for (int k = 0; k < 700; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    rem[ch] = $urandom_range(1, 12);
                end
                rem[ch] = rem[ch] - 1;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick(lvl[0], lvl[1], rst);
            checks++;
            if (bus.a !== exp_a) begin
                errors++;
                $display("[TB] FAIL random_a k=%0d got=%b want=%b", k, bus.a, exp_a);
            end
            checks++;
            if (bus.b !== exp_b) begin
                errors++;
                $display("[TB] FAIL random_b k=%0d got=%b want=%b", k, bus.b, exp_b);
            end
            checks++;
            if ((bus.a & bus.b) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random_excl k=%0d got a&b=%b want=0", k, bus.a & bus.b);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        bus.btn_a_raw = 1'b0;
        bus.btn_b_raw = 1'b0;
        reset         = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_glitch();
        test_simultaneous();
        test_reset_mid();
        test_reset_pending();
        test_repeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
